// File: rtl/demux_1xn_rr.sv
// demux_1xn_rr: 1-to-N_OUT demux, round-robin or explicit lane select, registered valid/ready lanes.
// Ports: clk, reset_L (async, active-low); in_valid/in_data/in_ready is the source handshake;
// mode (0 = round-robin, 1 = sel); out_valid/out_data/out_ready hold one word per lane, with
// lane i at out_data[i*DATA_W +: DATA_W]; rr_ptr is the striping pointer; sel_err flags an illegal sel.
module demux_1xn_rr #(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    reset_L,
    input  logic                    in_valid,
    input  logic [DATA_W-1:0]       in_data,
    output logic                    in_ready,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    output logic [N_OUT-1:0]        out_valid,
    output logic [N_OUT*DATA_W-1:0] out_data,
    input  logic [N_OUT-1:0]        out_ready,
    output logic [SEL_W-1:0]        rr_ptr,
    output logic                    sel_err
);
    logic [SEL_W-1:0] target;
    logic [N_OUT-1:0] hit, lane_free, load;
    logic             accept;
    // An out-of-range target decodes to an empty hit vector, so it blocks in_ready on its own.
    always_comb begin
        hit       = '0;
        target    = mode ? sel : rr_ptr;
        lane_free = ~out_valid | out_ready;
        for (int i = 0; i < N_OUT; i++) hit[i] = target == SEL_W'(i);
        in_ready  = |(hit & lane_free);
        accept    = in_valid & in_ready;
        load      = accept ? hit : '0;
    end
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            out_valid <= '0;
            out_data  <= '0;
            rr_ptr    <= '0;
            sel_err   <= 1'b0;
        end else begin
            sel_err <= in_valid & mode & ~|hit;
            if (accept & ~mode) rr_ptr <= rr_ptr == SEL_W'(N_OUT - 1) ? '0 : rr_ptr + 1'b1;
            for (int i = 0; i < N_OUT; i++) begin
                if (load[i]) begin
                    out_data[i*DATA_W +: DATA_W] <= in_data;
                    out_valid[i]                 <= 1'b1;
                end else if (out_ready[i]) begin
                    out_valid[i] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_demux_1xn_rr.sv
// tb_demux_1xn_rr: directed checks of demux_1xn_rr with N_OUT=4 and N_OUT=3 instances.
module tb_demux_1xn_rr;
    logic        clk = 1'b0;
    logic        reset_L = 1'b0;
    logic        in_valid4 = 1'b0, in_valid3 = 1'b0;
    logic [7:0]  in_data4 = '0, in_data3 = '0;
    logic        in_ready4, in_ready3;
    logic        mode4 = 1'b0, mode3 = 1'b0;
    logic [1:0]  sel4 = '0, sel3 = '0;
    logic [3:0]  out_valid4;
    logic [2:0]  out_valid3;
    logic [31:0] out_data4;
    logic [23:0] out_data3;
    logic [3:0]  out_ready4 = '0;
    logic [2:0]  out_ready3 = '0;
    logic [1:0]  rr_ptr4, rr_ptr3;
    logic        sel_err4, sel_err3;
    int          n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    demux_1xn_rr #(.DATA_W(8), .N_OUT(4), .SEL_W(2)) u4 (
        .clk(clk), .reset_L(reset_L), .in_valid(in_valid4), .in_data(in_data4),
        .in_ready(in_ready4), .mode(mode4), .sel(sel4), .out_valid(out_valid4),
        .out_data(out_data4), .out_ready(out_ready4), .rr_ptr(rr_ptr4), .sel_err(sel_err4)
    );

    demux_1xn_rr #(.DATA_W(8), .N_OUT(3), .SEL_W(2)) u3 (
        .clk(clk), .reset_L(reset_L), .in_valid(in_valid3), .in_data(in_data3),
        .in_ready(in_ready3), .mode(mode3), .sel(sel3), .out_valid(out_valid3),
        .out_data(out_data3), .out_ready(out_ready3), .rr_ptr(rr_ptr3), .sel_err(sel_err3)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    function automatic logic [7:0] lane4(input int i);
        return out_data4[i*8 +: 8];
    endfunction

    function automatic logic [7:0] lane3(input int i);
        return out_data3[i*8 +: 8];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        chk("rst_valid", 32'(out_valid4), 32'h0);
        chk("rst_data", out_data4, 32'h0);
        chk("rst_ptr", 32'(rr_ptr4), 32'h0);
        chk("rst_err", 32'(sel_err4), 32'h0);
        reset_L = 1'b1;
        tick();

        // Plain striping: word k lands on lane k%4.
        out_ready4 = 4'hf;
        in_valid4  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_data4 = 8'(k);
            #1;
            chk($sformatf("t1_ptr%0d", k), 32'(rr_ptr4), 32'(k % 4));
            chk($sformatf("t1_rdy%0d", k), 32'(in_ready4), 32'h1);
            tick();
            chk($sformatf("t1_val%0d", k), 32'(out_valid4), 32'(1 << (k % 4)));
            chk($sformatf("t1_dat%0d", k), 32'(lane4(k % 4)), 32'(k));
        end
        in_valid4 = 1'b0;
        tick();
        chk("t1_idle_val", 32'(out_valid4), 32'h0);
        chk("t1_wrap_ptr", 32'(rr_ptr4), 32'h0);

        // Lane 2 stalls; word 6 must wait for it while other lanes keep flowing.
        out_ready4 = 4'b1011;
        in_valid4  = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_data4 = 8'(k);
            tick();
        end
        in_data4 = 8'h06;
        #1;
        chk("t2_stall_rdy", 32'(in_ready4), 32'h0);
        chk("t2_stall_ptr", 32'(rr_ptr4), 32'h2);
        tick();
        chk("t2_hold_ptr", 32'(rr_ptr4), 32'h2);
        chk("t2_hold_val", 32'(out_valid4[2]), 32'h1);
        chk("t2_hold_dat", 32'(lane4(2)), 32'h02);
        chk("t2_hold_rdy", 32'(in_ready4), 32'h0);
        out_ready4 = 4'hf;
        #1;
        chk("t2_release_rdy", 32'(in_ready4), 32'h1);
        tick();
        chk("t2_l2_dat", 32'(lane4(2)), 32'h06);
        chk("t2_l2_val", 32'(out_valid4[2]), 32'h1);
        chk("t2_ptr3", 32'(rr_ptr4), 32'h3);
        in_data4 = 8'h07;
        tick();
        chk("t2_l3_dat", 32'(lane4(3)), 32'h07);
        chk("t2_l3_val", 32'(out_valid4), 32'b1000);
        chk("t2_ptr0", 32'(rr_ptr4), 32'h0);

        // Explicit select to lane 3, back to back; pointer untouched.
        mode4    = 1'b1;
        sel4     = 2'd3;
        in_data4 = 8'hA5;
        #1;
        chk("t3_rdy", 32'(in_ready4), 32'h1);
        tick();
        chk("t3_a5", 32'(lane4(3)), 32'hA5);
        chk("t3_val_a5", 32'(out_valid4), 32'b1000);
        in_data4 = 8'hA6;
        tick();
        chk("t3_a6", 32'(lane4(3)), 32'hA6);
        chk("t3_val_a6", 32'(out_valid4), 32'b1000);
        chk("t3_ptr", 32'(rr_ptr4), 32'h0);
        chk("t3_err", 32'(sel_err4), 32'h0);
        in_valid4 = 1'b0;
        mode4     = 1'b0;
        tick();

        // Three lanes: pointer wraps at 2, then an out-of-range sel is rejected.
        out_ready3 = 3'b111;
        in_valid3  = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_data3 = 8'(8'h10 + k);
            #1;
            chk($sformatf("t4_ptr%0d", k), 32'(rr_ptr3), 32'(k % 3));
            tick();
            chk($sformatf("t4_dat%0d", k), 32'(lane3(k % 3)), 32'(8'h10 + k));
            chk($sformatf("t4_val%0d", k), 32'(out_valid3), 32'(1 << (k % 3)));
        end
        chk("t4_l0_last", 32'(lane3(0)), 32'h13);
        mode3    = 1'b1;
        sel3     = 2'd3;
        in_data3 = 8'hEE;
        #1;
        chk("t4_bad_rdy", 32'(in_ready3), 32'h0);
        tick();
        chk("t4_err", 32'(sel_err3), 32'h1);
        chk("t4_bad_val", 32'(out_valid3), 32'h0);
        chk("t4_bad_ptr", 32'(rr_ptr3), 32'h0);
        chk("t4_bad_data", 32'(out_data3), 32'h151413);
        in_valid3 = 1'b0;
        tick();
        chk("t4_err_clr", 32'(sel_err3), 32'h0);
        mode3 = 1'b0;

        // Asynchronous reset while lanes hold words.
        out_ready4 = 4'h0;
        in_valid4  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data4 = 8'(8'h30 + k);
            tick();
        end
        in_valid4 = 1'b0;
        chk("t5_pre_val", 32'(out_valid4), 32'b0111);
        chk("t5_pre_ptr", 32'(rr_ptr4), 32'h3);
        #2;
        reset_L = 1'b0;
        #1;
        chk("t5_async_val", 32'(out_valid4), 32'h0);
        chk("t5_async_dat", out_data4, 32'h0);
        chk("t5_async_ptr", 32'(rr_ptr4), 32'h0);
        tick();
        #2;
        reset_L    = 1'b1;
        out_ready4 = 4'hf;
        in_valid4  = 1'b1;
        in_data4   = 8'h77;
        tick();
        chk("t5_first_dat", 32'(lane4(0)), 32'h77);
        chk("t5_first_val", 32'(out_valid4), 32'b0001);
        chk("t5_first_ptr", 32'(rr_ptr4), 32'h1);
        in_valid4 = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
